// File: rtl/expansion_port_arbiter_if.sv
// Expansion port arbiter bundle: two requester ports plus the
// external bus pins, viewed from the arbiter (slave) or the surroundings (master).
interface expansion_port_arbiter_if;
    logic       i_cpuReq;
    logic       i_cpuWrite;
    logic [7:0] i_cpuAddr;
    logic [7:0] i_cpuWdata;
    logic       o_cpuAck;
    logic [7:0] o_cpuRdata;

    logic       i_dbgReq;
    logic       i_dbgWrite;
    logic [7:0] i_dbgAddr;
    logic [7:0] i_dbgWdata;
    logic       o_dbgAck;
    logic [7:0] o_dbgRdata;

    logic [7:0] o_ramAddress;
    logic [7:0] o_busOut;
    logic       o_busDriveEn;
    logic [7:0] i_busIn;
    logic       o_ioNCE;
    logic       o_ctrlMemRamNOE;
    logic       o_ctrlMemRamNWE;
    logic       o_busy;
    logic       o_grantDbg;

    modport slave (
        input  i_cpuReq,
        input  i_cpuWrite,
        input  i_cpuAddr,
        input  i_cpuWdata,
        output o_cpuAck,
        output o_cpuRdata,
        input  i_dbgReq,
        input  i_dbgWrite,
        input  i_dbgAddr,
        input  i_dbgWdata,
        output o_dbgAck,
        output o_dbgRdata,
        output o_ramAddress,
        output o_busOut,
        output o_busDriveEn,
        input  i_busIn,
        output o_ioNCE,
        output o_ctrlMemRamNOE,
        output o_ctrlMemRamNWE,
        output o_busy,
        output o_grantDbg
    );

    modport master (
        output i_cpuReq,
        output i_cpuWrite,
        output i_cpuAddr,
        output i_cpuWdata,
        input  o_cpuAck,
        input  o_cpuRdata,
        output i_dbgReq,
        output i_dbgWrite,
        output i_dbgAddr,
        output i_dbgWdata,
        input  o_dbgAck,
        input  o_dbgRdata,
        input  o_ramAddress,
        input  o_busOut,
        input  o_busDriveEn,
        output i_busIn,
        input  o_ioNCE,
        input  o_ctrlMemRamNOE,
        input  o_ctrlMemRamNWE,
        input  o_busy,
        input  o_grantDbg
    );
endinterface

// File: rtl/expansion_port_arbiter.sv
// Round-robin arbiter sharing the expansion port between CPU and debug
// engine; each access runs setup / strobe / hold / ack with registered pins.
module expansion_port_arbiter #(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned STROBE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic i_clk100,
    input  logic i_resetn,
    expansion_port_arbiter_if.slave bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] STROBE = 3'd2;
    localparam logic [2:0] HOLD   = 3'd3;
    localparam logic [2:0] ACK    = 3'd4;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

    logic [2:0] state;
    logic [2:0] nextState;
    logic [3:0] phaseCnt;
    logic [3:0] nextCnt;

    logic       txWrite;
    logic       lastStrobe;
    logic [7:0] busInReg;
    logic [7:0] rdCap;
    logic [7:0] capVal;

    logic       anyReq;
    logic       winDbg;
    logic       winWrite;
    logic [7:0] winAddr;
    logic [7:0] winWdata;
    logic       wrNext;
    logic       inTx;

    // The last-grant register doubles as o_grantDbg: on a tie the
    // requester that did not own the previous transfer wins.
    always_comb begin
        anyReq = bus.i_cpuReq | bus.i_dbgReq;
        winDbg = bus.i_dbgReq & (~bus.i_cpuReq | ~bus.o_grantDbg);
        unique case (1'b1)
            winDbg: begin
                winWrite = bus.i_dbgWrite;
                winAddr  = bus.i_dbgAddr;
                winWdata = bus.i_dbgWdata;
            end
            default: begin
                winWrite = bus.i_cpuWrite;
                winAddr  = bus.i_cpuAddr;
                winWdata = bus.i_cpuWdata;
            end
        endcase
    end

    always_comb begin
        nextState = state;
        nextCnt   = phaseCnt;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    nextState = SETUP;
                    nextCnt   = SETUP_LD;
                end
            end
            SETUP: begin
                if (phaseCnt == 4'd0) begin
                    nextState = STROBE;
                    nextCnt   = STROBE_LD;
                end else begin
                    nextCnt = phaseCnt - 4'd1;
                end
            end
            STROBE: begin
                if (phaseCnt == 4'd0) begin
                    nextState = HOLD;
                    nextCnt   = HOLD_LD;
                end else begin
                    nextCnt = phaseCnt - 4'd1;
                end
            end
            HOLD: begin
                if (phaseCnt == 4'd0) begin
                    nextState = ACK;
                    nextCnt   = 4'd0;
                end else begin
                    nextCnt = phaseCnt - 4'd1;
                end
            end
            ACK: begin
                nextState = IDLE;
                nextCnt   = 4'd0;
            end
            default: begin
                nextState = IDLE;
                nextCnt   = 4'd0;
            end
        endcase
    end

    // Pins are registered, so they are derived from the upcoming state.
    always_comb begin
        wrNext = (state == IDLE) ? winWrite : txWrite;
        inTx   = (nextState == SETUP) ||
                 (nextState == STROBE) ||
                 (nextState == HOLD);
        capVal = lastStrobe ? busInReg : rdCap;
    end

    always_ff @(posedge i_clk100 or negedge i_resetn) begin
        if (!i_resetn) begin
            state      <= IDLE;
            phaseCnt   <= 4'd0;
            txWrite    <= 1'b0;
            lastStrobe <= 1'b0;
            busInReg   <= 8'h00;
            rdCap      <= 8'h00;
        end else begin
            state      <= nextState;
            phaseCnt   <= nextCnt;
            busInReg   <= bus.i_busIn;
            lastStrobe <= (state == STROBE) && (phaseCnt == 4'd0);
            if (lastStrobe) begin
                rdCap <= busInReg;
            end
            if (state == IDLE && anyReq) begin
                txWrite <= winWrite;
            end
        end
    end

    always_ff @(posedge i_clk100 or negedge i_resetn) begin
        if (!i_resetn) begin
            bus.o_ioNCE         <= 1'b1;
            bus.o_ctrlMemRamNOE <= 1'b1;
            bus.o_ctrlMemRamNWE <= 1'b1;
            bus.o_busDriveEn    <= 1'b0;
            bus.o_ramAddress    <= 8'h00;
            bus.o_busOut        <= 8'h00;
            bus.o_cpuRdata      <= 8'h00;
            bus.o_dbgRdata      <= 8'h00;
            bus.o_cpuAck        <= 1'b0;
            bus.o_dbgAck        <= 1'b0;
            bus.o_busy          <= 1'b0;
            bus.o_grantDbg      <= 1'b1;
        end else begin
            if (state == IDLE && anyReq) begin
                bus.o_grantDbg   <= winDbg;
                bus.o_ramAddress <= winAddr;
                bus.o_busOut     <= winWdata;
            end
            bus.o_ioNCE         <= ~inTx;
            bus.o_ctrlMemRamNOE <= ~((nextState == STROBE) & ~wrNext);
            bus.o_ctrlMemRamNWE <= ~((nextState == STROBE) & wrNext);
            bus.o_busDriveEn    <= inTx & wrNext;
            bus.o_busy          <= (nextState != IDLE);
            bus.o_cpuAck <= (nextState == ACK) & ~bus.o_grantDbg;
            bus.o_dbgAck <= (nextState == ACK) & bus.o_grantDbg;
            if (state == HOLD && nextState == ACK && !txWrite) begin
                if (bus.o_grantDbg) begin
                    bus.o_dbgRdata <= capVal;
                end else begin
                    bus.o_cpuRdata <= capVal;
                end
            end
        end
    end

endmodule

// File: tb/tb_expansion_port_arbiter.sv
// Directed bench for expansion_port_arbiter: default timing instance
// plus a minimum-timing instance, checked with immediate assertions.
module tb_expansion_port_arbiter;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   tests = 0;
    int   fails = 0;

    expansion_port_arbiter_if b();
    expansion_port_arbiter_if p();

    expansion_port_arbiter dut (
        .i_clk100 (clk),
        .i_resetn (rstn),
        .bus      (b)
    );

    expansion_port_arbiter #(
        .SETUP_CYCLES  (1),
        .STROBE_CYCLES (1),
        .HOLD_CYCLES   (1)
    ) dutP (
        .i_clk100 (clk),
        .i_resetn (rstn),
        .bus      (p)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        b.i_cpuReq = 0; b.i_cpuWrite = 0; b.i_cpuAddr = 0; b.i_cpuWdata = 0;
        b.i_dbgReq = 0; b.i_dbgWrite = 0; b.i_dbgAddr = 0; b.i_dbgWdata = 0;
        b.i_busIn  = 8'h00;
        p.i_cpuReq = 0; p.i_cpuWrite = 0; p.i_cpuAddr = 0; p.i_cpuWdata = 0;
        p.i_dbgReq = 0; p.i_dbgWrite = 0; p.i_dbgAddr = 0; p.i_dbgWdata = 0;
        p.i_busIn  = 8'hFF;

        tick;
        tick;
        chk1("rst_nce", b.o_ioNCE, 1'b1);
        chk1("rst_noe", b.o_ctrlMemRamNOE, 1'b1);
        chk1("rst_nwe", b.o_ctrlMemRamNWE, 1'b1);
        chk1("rst_drv", b.o_busDriveEn, 1'b0);
        chk8("rst_addr", b.o_ramAddress, 8'h00);
        chk8("rst_bout", b.o_busOut, 8'h00);
        chk8("rst_crd", b.o_cpuRdata, 8'h00);
        chk8("rst_drd", b.o_dbgRdata, 8'h00);
        chk1("rst_cack", b.o_cpuAck, 1'b0);
        chk1("rst_dack", b.o_dbgAck, 1'b0);
        chk1("rst_busy", b.o_busy, 1'b0);
        chk1("rst_gnt", b.o_grantDbg, 1'b1);
        rstn = 1'b1;

        // CPU read 0x3C, bus value changes after strobe ends
        b.i_cpuReq = 1; b.i_cpuWrite = 0; b.i_cpuAddr = 8'h3C;
        for (int c = 1; c <= 9; c++) begin
            tick;
            if (c == 2) b.i_cpuAddr = 8'hFF;
            if (c == 3) b.i_busIn = 8'hA5;
            if (c == 7) b.i_busIn = 8'h11;
            chk1("rd_nce", b.o_ioNCE, !(c <= 7));
            chk1("rd_noe", b.o_ctrlMemRamNOE, !(c >= 3 && c <= 6));
            chk1("rd_nwe", b.o_ctrlMemRamNWE, 1'b1);
            chk1("rd_drv", b.o_busDriveEn, 1'b0);
            chk1("rd_cack", b.o_cpuAck, c == 8);
            chk1("rd_dack", b.o_dbgAck, 1'b0);
            chk1("rd_busy", b.o_busy, c <= 8);
            if (c <= 7) chk8("rd_addr", b.o_ramAddress, 8'h3C);
            if (c == 8) begin
                chk8("rd_data", b.o_cpuRdata, 8'hA5);
                chk1("rd_gnt", b.o_grantDbg, 1'b0);
                b.i_cpuReq = 0;
            end
        end

        // Debug write 0x5A to 0x10
        b.i_dbgReq = 1; b.i_dbgWrite = 1;
        b.i_dbgAddr = 8'h10; b.i_dbgWdata = 8'h5A;
        for (int c = 1; c <= 9; c++) begin
            tick;
            if (c == 4) b.i_dbgWdata = 8'h00;
            chk1("wr_nce", b.o_ioNCE, !(c <= 7));
            chk1("wr_nwe", b.o_ctrlMemRamNWE, !(c >= 3 && c <= 6));
            chk1("wr_noe", b.o_ctrlMemRamNOE, 1'b1);
            chk1("wr_drv", b.o_busDriveEn, c <= 7);
            chk1("wr_dack", b.o_dbgAck, c == 8);
            chk1("wr_cack", b.o_cpuAck, 1'b0);
            chk8("wr_crd", b.o_cpuRdata, 8'hA5);
            if (c <= 7) begin
                chk8("wr_bout", b.o_busOut, 8'h5A);
                chk8("wr_addr", b.o_ramAddress, 8'h10);
            end
            if (c == 8) begin
                chk1("wr_gnt", b.o_grantDbg, 1'b1);
                b.i_dbgReq = 0;
            end
        end

        // Both requesters held from reset: CPU, DBG, CPU, DBG
        #2;
        rstn = 1'b0;
        #1;
        chk1("rr_rst_busy", b.o_busy, 1'b0);
        b.i_cpuReq = 1; b.i_cpuWrite = 0; b.i_cpuAddr = 8'h01;
        b.i_dbgReq = 1; b.i_dbgWrite = 0; b.i_dbgAddr = 8'h02;
        b.i_busIn = 8'h77;
        tick;
        tick;
        chk1("rr_rst_gnt", b.o_grantDbg, 1'b1);
        rstn = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            logic isAck;
            logic dbgTurn;
            tick;
            isAck   = (c >= 8) && ((c - 8) % 9 == 0);
            dbgTurn = (c >= 8) && (((c - 8) / 9) % 2 == 1);
            chk1("rr_cack", b.o_cpuAck, isAck && !dbgTurn);
            chk1("rr_dack", b.o_dbgAck, isAck && dbgTurn);
            chk1("rr_busy", b.o_busy, !(c >= 9 && (c - 9) % 9 == 0));
            if (isAck) chk1("rr_gnt", b.o_grantDbg, dbgTurn);
            if (c == 17) chk8("rr_drd", b.o_dbgRdata, 8'h77);
            if (c == 35) begin
                b.i_cpuReq = 0;
                b.i_dbgReq = 0;
            end
        end

        // Reset in the 2nd strobe cycle of a CPU write
        b.i_cpuReq = 1; b.i_cpuWrite = 1;
        b.i_cpuAddr = 8'h22; b.i_cpuWdata = 8'h99;
        for (int c = 1; c <= 4; c++) begin
            tick;
            chk1("ar_nce", b.o_ioNCE, 1'b0);
        end
        chk1("ar_nwe_pre", b.o_ctrlMemRamNWE, 1'b0);
        chk1("ar_drv_pre", b.o_busDriveEn, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk1("ar_nwe", b.o_ctrlMemRamNWE, 1'b1);
        chk1("ar_nce_rst", b.o_ioNCE, 1'b1);
        chk1("ar_drv", b.o_busDriveEn, 1'b0);
        chk1("ar_busy_rst", b.o_busy, 1'b0);
        b.i_cpuReq = 0;
        tick;
        tick;
        rstn = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick;
            chk1("ar_cack", b.o_cpuAck, 1'b0);
            chk1("ar_busy", b.o_busy, 1'b0);
            chk1("ar_nce", b.o_ioNCE, 1'b1);
        end

        // CPU request dropped during setup
        b.i_cpuReq = 1; b.i_cpuWrite = 0; b.i_cpuAddr = 8'h44;
        for (int c = 1; c <= 12; c++) begin
            tick;
            if (c == 1) b.i_cpuReq = 0;
            chk1("dr_cack", b.o_cpuAck, c == 8);
            chk1("dr_nce", b.o_ioNCE, !(c <= 7));
            chk1("dr_busy", b.o_busy, c <= 8);
            if (c == 8) chk8("dr_crd", b.o_cpuRdata, 8'h77);
        end

        // Minimum timing instance: read of 0xFF
        p.i_cpuReq = 1; p.i_cpuWrite = 0; p.i_cpuAddr = 8'h80;
        for (int c = 1; c <= 6; c++) begin
            tick;
            chk1("mp_noe", p.o_ctrlMemRamNOE, !(c == 2));
            chk1("mp_nce", p.o_ioNCE, !(c <= 3));
            chk1("mp_cack", p.o_cpuAck, c == 4);
            if (c == 4) begin
                chk8("mp_crd", p.o_cpuRdata, 8'hFF);
                p.i_cpuReq = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
